// File: rtl/esi_cosim_bytelist_unpack.sv
// Unpacks a flat Cap'n Proto {root ptr, List(UInt8) ptr, body} message
// into a valid/ready byte stream; malformed messages are dropped and counted.
module esi_cosim_bytelist_unpack #(
  parameter  int MSG_WORDS = 3,
  localparam int MSG_BITS  = 64 * MSG_WORDS,
  localparam int MAX_BYTES = 8 * (MSG_WORDS - 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [MSG_BITS-1:0] msg_data,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [7:0]          byte_data,
  output logic                byte_last,
  output logic                err_pulse,
  output logic [15:0]         err_count
);

  localparam int IWR  = $clog2(MAX_BYTES + 1);
  localparam int IW   = (IWR < 1) ? 1 : IWR;
  localparam int BODY = MSG_BITS - 128;
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic [BODY-1:0] body;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   cnt;

  logic [63:0] w0;
  logic [63:0] w1;
  logic [28:0] count;
  logic        rootOk;
  logic        listOk;
  logic        msgOk;
  logic        accept;
  logic [IW-1:0] idxNext;
  logic        lastNext;
  logic        unusedDataSize;

  assign w0    = msg_data[63:0];
  assign w1    = msg_data[127:64];
  assign count = w1[63:35];

  // Data-section size of the root struct is irrelevant here.
  assign unusedDataSize = ^w0[47:32];

  assign rootOk = (w0[31:0] == 32'd0)
               && (w0[63:48] != 16'd0);
  assign listOk = (w1[1:0] == 2'd1)
               && (w1[31:2] == 30'd0)
               && (w1[34:32] == 3'd2)
               && (count <= 29'(MAX_BYTES));
  assign msgOk  = rootOk && listOk;

  assign msg_ready = (state == IDLE);
  assign accept    = msg_valid && msg_ready;

  assign idxNext  = idx + ONE;
  assign lastNext = (idxNext == cnt - ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      body       <= '0;
      idx        <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_last  <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= 16'd0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            body <= msg_data[MSG_BITS-1:128];
            if (!msgOk) begin
              err_pulse <= 1'b1;
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            end else if (count != 29'd0) begin
              state      <= STREAM;
              cnt        <= count[IW-1:0];
              idx        <= '0;
              byte_valid <= 1'b1;
              byte_data  <= msg_data[135:128];
              byte_last  <= (count == 29'd1);
            end
          end
        end
        STREAM: begin
          if (byte_ready) begin
            if (byte_last) begin
              state      <= IDLE;
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
            end else begin
              // body[7:0] always holds the byte being presented
              idx       <= idxNext;
              body      <= body >> 8;
              byte_data <= body[15:8];
              byte_last <= lastNext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esi_cosim_bytelist_unpack.sv
// Scoreboard bench for esi_cosim_bytelist_unpack: directed messages,
// expected bytes/errors queued by stimulus, popped by a negedge monitor.
module tb_esi_cosim_bytelist_unpack;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [191:0] msg_data = '0;
  logic         byte_valid;
  logic         byte_ready = 1'b1;
  logic [7:0]   byte_data;
  logic         byte_last;
  logic         err_pulse;
  logic [15:0]  err_count;

  esi_cosim_bytelist_unpack #(.MSG_WORDS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] W0OK = 64'h0001000000000000;
  localparam logic [63:0] W1OK = 64'h0000001A00000001;
  localparam logic [63:0] W2OK = 64'h0000000000CCBBAA;

  int nChecks = 0;
  int nPass = 0;
  int nHs = 0;
  int nErr = 0;

  logic [8:0]  byteQ[$];
  logic [15:0] errQ[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    nChecks++;
    $display("FAIL %s: got timeout/unexpected want event", name);
  endtask

  function automatic logic [191:0] mk(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input logic [63:0] c);
    return {c, b, a};
  endfunction

  task automatic pushGood();
    byteQ.push_back({1'b0, 8'hAA});
    byteQ.push_back({1'b0, 8'hBB});
    byteQ.push_back({1'b1, 8'hCC});
  endtask

  // Called just after a posedge; returns #1 after the accept edge.
  task automatic sendMsg(input logic [191:0] m);
    int t = 0;
    msg_data  = m;
    msg_valid = 1'b1;
    @(negedge clk);
    while (!msg_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) failNow("msg_accept");
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while (byteQ.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50) failNow("drain");
    @(posedge clk);
    #1;
  endtask

  logic       stalled = 1'b0;
  logic [8:0] held;
  logic [8:0] expB;

  always @(negedge clk) begin
    if (rst) begin
      if (stalled)
        check("stall_hold", 32'({byte_valid, byte_last, byte_data}),
              32'({1'b1, held}));
      if (byte_valid && byte_ready) begin
        nHs++;
        if (byteQ.size() == 0) failNow("byte_unexpected");
        else begin
          expB = byteQ.pop_front();
          check("byte", 32'({byte_last, byte_data}), 32'(expB));
        end
      end
      stalled = byte_valid && !byte_ready;
      held    = {byte_last, byte_data};
      if (err_pulse) begin
        nErr++;
        if (errQ.size() == 0) failNow("err_unexpected");
        else check("err_count_at_pulse", 32'(err_count),
                   32'(errQ.pop_front()));
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [6];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_last", 32'(byte_last), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_msg_ready", 32'(msg_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    pushGood();
    sendMsg(mk(W0OK, W1OK, W2OK));
    check("lat_valid", 32'(byte_valid), 32'd1);
    check("lat_data", 32'(byte_data), 32'hAA);
    check("lat_ready_low", 32'(msg_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("good_ready_back", 32'(msg_ready), 32'd1);
    check("good_valid_off", 32'(byte_valid), 32'd0);
    check("good_err_count", 32'(err_count), 32'd0);
    check("good_hs", 32'(nHs), 32'd3);

    pushGood();
    sendMsg(mk(W0OK, W1OK, W2OK));
    for (int i = 0; i < 6; i++) begin
      byte_ready = pat[i];
      check("stall_ready_low", 32'(msg_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("stall_ready_back", 32'(msg_ready), 32'd1);
    check("stall_hs", 32'(nHs), 32'd6);
    byte_ready = 1'b1;

    errQ.push_back(16'd1);
    errQ.push_back(16'd2);
    errQ.push_back(16'd3);
    sendMsg(mk(W0OK, 64'h0000001B00000001, W2OK));
    sendMsg(mk(W0OK, 64'h0000004A00000001, W2OK));
    sendMsg(mk(64'h0001000000000001, W1OK, W2OK));
    @(posedge clk);
    #1;
    check("bad_err_count", 32'(err_count), 32'd3);
    check("bad_pulses", 32'(nErr), 32'd3);
    check("bad_no_bytes", 32'(nHs), 32'd6);
    check("bad_valid_off", 32'(byte_valid), 32'd0);

    sendMsg(mk(W0OK, 64'h0000000200000001, W2OK));
    check("c0_ready", 32'(msg_ready), 32'd1);
    check("c0_valid", 32'(byte_valid), 32'd0);
    check("c0_err_pulse", 32'(err_pulse), 32'd0);
    check("c0_err_count", 32'(err_count), 32'd3);

    byteQ.push_back({1'b0, 8'hAA});
    byteQ.push_back({1'b0, 8'hBB});
    sendMsg(mk(W0OK, W1OK, W2OK));
    repeat (2) @(posedge clk);
    #1;
    check("mid_cc_present", 32'({byte_valid, byte_last, byte_data}),
          32'({1'b1, 1'b1, 8'hCC}));
    rst = 1'b0;
    byte_ready = 1'b0;
    byteQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    byte_ready = 1'b1;
    check("mid_valid_off", 32'(byte_valid), 32'd0);
    check("mid_idle", 32'(msg_ready), 32'd1);
    check("mid_err_count", 32'(err_count), 32'd0);
    check("mid_hs", 32'(nHs), 32'd8);
    pushGood();
    sendMsg(mk(W0OK, W1OK, W2OK));
    waitDrain();
    check("post_rst_hs", 32'(nHs), 32'd11);
    check("post_rst_ready", 32'(msg_ready), 32'd1);

    for (int i = 1; i <= 16'hFFFE; i++) begin
      errQ.push_back(16'(i));
      sendMsg(mk(W0OK, 64'h0000001B00000001, W2OK));
    end
    errQ.push_back(16'hFFFF);
    errQ.push_back(16'hFFFF);
    sendMsg(mk(W0OK, 64'h0000001B00000001, W2OK));
    sendMsg(mk(W0OK, 64'h0000001B00000001, W2OK));
    @(posedge clk);
    #1;
    check("sat_err_count", 32'(err_count), 32'hFFFF);
    check("sat_pulses", 32'(nErr), 32'(3 + 16'hFFFE + 2));
    check("sat_errq_empty", 32'(errQ.size()), 32'd0);
    check("end_byteq_empty", 32'(byteQ.size()), 32'd0);
    check("end_hs", 32'(nHs), 32'd11);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
